// File: rtl/msrh_l2_req_arbiter.sv
// Round-robin merge of the ic and l1d request streams onto one registered L2 port,
// with response routing by source tag bit. Define MSRH_L2_ARB_RESP_REG_EN to register the response path.
module msrh_l2_req_arbiter #(
    parameter int PADDR_W         = 56,
    parameter int DATA_W          = 512,
    parameter int TAG_W           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,

    input  logic               i_ic_req_valid,
    output logic               o_ic_req_ready,
    input  logic [1:0]         i_ic_req_cmd,
    input  logic [PADDR_W-1:0] i_ic_req_addr,
    input  logic [TAG_W-1:0]   i_ic_req_tag,
    input  logic [DATA_W-1:0]  i_ic_req_data,

    input  logic               i_l1d_req_valid,
    output logic               o_l1d_req_ready,
    input  logic [1:0]         i_l1d_req_cmd,
    input  logic [PADDR_W-1:0] i_l1d_req_addr,
    input  logic [TAG_W-1:0]   i_l1d_req_tag,
    input  logic [DATA_W-1:0]  i_l1d_req_data,

    output logic               o_ic_resp_valid,
    input  logic               i_ic_resp_ready,
    output logic [TAG_W-1:0]   o_ic_resp_tag,
    output logic [DATA_W-1:0]  o_ic_resp_data,

    output logic               o_l1d_resp_valid,
    input  logic               i_l1d_resp_ready,
    output logic [TAG_W-1:0]   o_l1d_resp_tag,
    output logic [DATA_W-1:0]  o_l1d_resp_data,

    output logic               o_l2_req_valid,
    input  logic               i_l2_req_ready,
    output logic [1:0]         o_l2_req_cmd,
    output logic [PADDR_W-1:0] o_l2_req_addr,
    output logic [TAG_W:0]     o_l2_req_tag,
    output logic [DATA_W-1:0]  o_l2_req_data,

    input  logic               i_l2_resp_valid,
    output logic               o_l2_resp_ready,
    input  logic [TAG_W:0]     i_l2_resp_tag,
    input  logic [DATA_W-1:0]  i_l2_resp_data,

    output logic               o_protocol_err
);

    localparam logic [3:0] MaxCnt = 4'(MAX_OUTSTANDING);

    // rr_ptr: 0 = ic has priority, 1 = l1d has priority
    logic               rr_ptr_q, rr_ptr_d;
    logic [3:0]         cnt_ic_q, cnt_ic_d;
    logic [3:0]         cnt_l1d_q, cnt_l1d_d;
    logic               err_q, err_d;

    logic               req_vld_q, req_vld_d;
    logic [1:0]         req_cmd_q, req_cmd_d;
    logic [PADDR_W-1:0] req_addr_q, req_addr_d;
    logic [TAG_W:0]     req_tag_q, req_tag_d;
    logic [DATA_W-1:0]  req_data_q, req_data_d;

    logic stage_free, elig_ic, elig_l1d, grant_ic, grant_l1d;
    logic resp_hs_ic, resp_hs_l1d;

    // A decrement against an empty count is the protocol error case and is dropped.
    function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc,
                                            input logic dec);
        logic dec_eff;
        dec_eff = dec && (cnt != 4'd0);
        case ({inc, dec_eff})
            2'b10:   return cnt + 4'd1;
            2'b01:   return cnt - 4'd1;
            default: return cnt;
        endcase
    endfunction

    always_comb begin
        stage_free = !req_vld_q || i_l2_req_ready;
        elig_ic    = i_ic_req_valid && (cnt_ic_q < MaxCnt);
        elig_l1d   = i_l1d_req_valid && (cnt_l1d_q < MaxCnt);
        grant_ic   = i_reset_n && stage_free && elig_ic && (!elig_l1d || !rr_ptr_q);
        grant_l1d  = i_reset_n && stage_free && elig_l1d && (!elig_ic || rr_ptr_q);
    end

    assign o_ic_req_ready  = grant_ic;
    assign o_l1d_req_ready = grant_l1d;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        req_vld_d  = req_vld_q;
        req_cmd_d  = req_cmd_q;
        req_addr_d = req_addr_q;
        req_tag_d  = req_tag_q;
        req_data_d = req_data_q;
        if (stage_free) begin
            req_vld_d = grant_ic || grant_l1d;
        end
        if (grant_ic) begin
            rr_ptr_d   = 1'b1;
            req_cmd_d  = i_ic_req_cmd;
            req_addr_d = i_ic_req_addr;
            req_tag_d  = {1'b0, i_ic_req_tag};
            req_data_d = i_ic_req_data;
        end else if (grant_l1d) begin
            rr_ptr_d   = 1'b0;
            req_cmd_d  = i_l1d_req_cmd;
            req_addr_d = i_l1d_req_addr;
            req_tag_d  = {1'b1, i_l1d_req_tag};
            req_data_d = i_l1d_req_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            req_vld_q <= 1'b0;
            rr_ptr_q  <= 1'b0;
            cnt_ic_q  <= 4'd0;
            cnt_l1d_q <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            req_vld_q <= req_vld_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_ic_q  <= cnt_ic_d;
            cnt_l1d_q <= cnt_l1d_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        req_cmd_q  <= req_cmd_d;
        req_addr_q <= req_addr_d;
        req_tag_q  <= req_tag_d;
        req_data_q <= req_data_d;
    end

    assign o_l2_req_valid = req_vld_q;
    assign o_l2_req_cmd   = req_cmd_q;
    assign o_l2_req_addr  = req_addr_q;
    assign o_l2_req_tag   = req_tag_q;
    assign o_l2_req_data  = req_data_q;

`ifdef MSRH_L2_ARB_RESP_REG_EN
    logic               resp_full_q, resp_full_d;
    logic               resp_src_q;
    logic [TAG_W-1:0]   resp_tag_q;
    logic [DATA_W-1:0]  resp_data_q;
    logic               resp_out_hs, resp_load;

    assign o_ic_resp_valid  = resp_full_q && !resp_src_q;
    assign o_l1d_resp_valid = resp_full_q && resp_src_q;
    assign o_ic_resp_tag    = resp_tag_q;
    assign o_l1d_resp_tag   = resp_tag_q;
    assign o_ic_resp_data   = resp_data_q;
    assign o_l1d_resp_data  = resp_data_q;

    always_comb begin
        resp_out_hs     = (o_ic_resp_valid && i_ic_resp_ready)
                       || (o_l1d_resp_valid && i_l1d_resp_ready);
        o_l2_resp_ready = !resp_full_q || resp_out_hs;
        resp_load       = i_l2_resp_valid && o_l2_resp_ready;
        resp_full_d     = resp_load || (resp_full_q && !resp_out_hs);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            resp_full_q <= 1'b0;
        end else begin
            resp_full_q <= resp_full_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (resp_load) begin
            resp_src_q  <= i_l2_resp_tag[TAG_W];
            resp_tag_q  <= i_l2_resp_tag[TAG_W-1:0];
            resp_data_q <= i_l2_resp_data;
        end
    end
`else
    logic resp_src;

    always_comb begin
        resp_src         = i_l2_resp_tag[TAG_W];
        o_ic_resp_valid  = i_reset_n && i_l2_resp_valid && !resp_src;
        o_l1d_resp_valid = i_reset_n && i_l2_resp_valid && resp_src;
        o_ic_resp_tag    = i_l2_resp_tag[TAG_W-1:0];
        o_l1d_resp_tag   = i_l2_resp_tag[TAG_W-1:0];
        o_ic_resp_data   = i_l2_resp_data;
        o_l1d_resp_data  = i_l2_resp_data;
        o_l2_resp_ready  = resp_src ? i_l1d_resp_ready : i_ic_resp_ready;
    end
`endif

    always_comb begin
        resp_hs_ic  = o_ic_resp_valid && i_ic_resp_ready;
        resp_hs_l1d = o_l1d_resp_valid && i_l1d_resp_ready;
        cnt_ic_d    = cnt_next(cnt_ic_q, grant_ic, resp_hs_ic);
        cnt_l1d_d   = cnt_next(cnt_l1d_q, grant_l1d, resp_hs_l1d);
        err_d       = err_q || (resp_hs_ic && (cnt_ic_q == 4'd0))
                            || (resp_hs_l1d && (cnt_l1d_q == 4'd0));
    end

    assign o_protocol_err = err_q;

endmodule

// File: tb/tb_msrh_l2_req_arbiter.sv
// Scoreboard bench for msrh_l2_req_arbiter: random traffic against a queue-based model,
// then directed error, outstanding-limit, stall and reset scenarios.
module tb_msrh_l2_req_arbiter;
    localparam int PA = 56;
    localparam int DW = 64;
    localparam int TW = 4;
    localparam int MO = 4;

    typedef struct packed {
        logic [1:0]    cmd;
        logic [PA-1:0] addr;
        logic [TW:0]   tag;
        logic [DW-1:0] data;
    } l2req_t;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_reset_n;
    logic          i_ic_req_valid, o_ic_req_ready;
    logic [1:0]    i_ic_req_cmd;
    logic [PA-1:0] i_ic_req_addr;
    logic [TW-1:0] i_ic_req_tag;
    logic [DW-1:0] i_ic_req_data;
    logic          i_l1d_req_valid, o_l1d_req_ready;
    logic [1:0]    i_l1d_req_cmd;
    logic [PA-1:0] i_l1d_req_addr;
    logic [TW-1:0] i_l1d_req_tag;
    logic [DW-1:0] i_l1d_req_data;
    logic          o_ic_resp_valid, i_ic_resp_ready;
    logic [TW-1:0] o_ic_resp_tag;
    logic [DW-1:0] o_ic_resp_data;
    logic          o_l1d_resp_valid, i_l1d_resp_ready;
    logic [TW-1:0] o_l1d_resp_tag;
    logic [DW-1:0] o_l1d_resp_data;
    logic          o_l2_req_valid, i_l2_req_ready;
    logic [1:0]    o_l2_req_cmd;
    logic [PA-1:0] o_l2_req_addr;
    logic [TW:0]   o_l2_req_tag;
    logic [DW-1:0] o_l2_req_data;
    logic          i_l2_resp_valid, o_l2_resp_ready;
    logic [TW:0]   i_l2_resp_tag;
    logic [DW-1:0] i_l2_resp_data;
    logic          o_protocol_err;

    msrh_l2_req_arbiter #(
        .PADDR_W(PA), .DATA_W(DW), .TAG_W(TW), .MAX_OUTSTANDING(MO)
    ) dut (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_ic_req_valid(i_ic_req_valid), .o_ic_req_ready(o_ic_req_ready),
        .i_ic_req_cmd(i_ic_req_cmd), .i_ic_req_addr(i_ic_req_addr),
        .i_ic_req_tag(i_ic_req_tag), .i_ic_req_data(i_ic_req_data),
        .i_l1d_req_valid(i_l1d_req_valid), .o_l1d_req_ready(o_l1d_req_ready),
        .i_l1d_req_cmd(i_l1d_req_cmd), .i_l1d_req_addr(i_l1d_req_addr),
        .i_l1d_req_tag(i_l1d_req_tag), .i_l1d_req_data(i_l1d_req_data),
        .o_ic_resp_valid(o_ic_resp_valid), .i_ic_resp_ready(i_ic_resp_ready),
        .o_ic_resp_tag(o_ic_resp_tag), .o_ic_resp_data(o_ic_resp_data),
        .o_l1d_resp_valid(o_l1d_resp_valid), .i_l1d_resp_ready(i_l1d_resp_ready),
        .o_l1d_resp_tag(o_l1d_resp_tag), .o_l1d_resp_data(o_l1d_resp_data),
        .o_l2_req_valid(o_l2_req_valid), .i_l2_req_ready(i_l2_req_ready),
        .o_l2_req_cmd(o_l2_req_cmd), .o_l2_req_addr(o_l2_req_addr),
        .o_l2_req_tag(o_l2_req_tag), .o_l2_req_data(o_l2_req_data),
        .i_l2_resp_valid(i_l2_resp_valid), .o_l2_resp_ready(o_l2_resp_ready),
        .i_l2_resp_tag(i_l2_resp_tag), .i_l2_resp_data(i_l2_resp_data),
        .o_protocol_err(o_protocol_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            cnt0, cnt1;
    bit            pri_m;          // 0: ic preferred on a tie, 1: l1d preferred
    l2req_t        stage_q[$];     // granted, not yet taken by L2
    logic [TW:0]   infl_q[$];      // taken by L2, awaiting response
    resp_t         exp_q0[$], exp_q1[$];
    bit            rsp_act;
    bit            exp_l2_vld, exp_rv0, exp_rv1;
    bit            mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_ic_req_valid = 0; i_ic_req_cmd = 0; i_ic_req_addr = 0; i_ic_req_tag = 0; i_ic_req_data = 0;
        i_l1d_req_valid = 0; i_l1d_req_cmd = 0; i_l1d_req_addr = 0; i_l1d_req_tag = 0; i_l1d_req_data = 0;
        i_ic_resp_ready = 0; i_l1d_resp_ready = 0; i_l2_req_ready = 0;
        i_l2_resp_valid = 0; i_l2_resp_tag = 0; i_l2_resp_data = 0;
    endtask

    task automatic drive_cycle(input bit allow_req);
        int k;
        bit free, e0, e1, g0, g1, src, hs0, hs1;
        @(negedge clk);
        i_ic_req_valid  = allow_req && ($urandom_range(0, 99) < 60);
        i_ic_req_cmd    = 2'($urandom_range(0, 2));
        i_ic_req_addr   = PA'({$urandom, $urandom});
        i_ic_req_tag    = TW'($urandom);
        i_ic_req_data   = DW'({$urandom, $urandom});
        i_l1d_req_valid = allow_req && ($urandom_range(0, 99) < 60);
        i_l1d_req_cmd   = 2'($urandom_range(0, 2));
        i_l1d_req_addr  = PA'({$urandom, $urandom});
        i_l1d_req_tag   = TW'($urandom);
        i_l1d_req_data  = DW'({$urandom, $urandom});
        i_l2_req_ready  = ($urandom_range(0, 99) < 70);
        if (!rsp_act && infl_q.size() > 0 && $urandom_range(0, 99) < 45) begin
            k = $urandom_range(0, infl_q.size() - 1);
            i_l2_resp_tag  = infl_q[k];
            infl_q.delete(k);
            i_l2_resp_data = DW'({$urandom, $urandom});
            rsp_act = 1'b1;
            if (i_l2_resp_tag[TW]) exp_q1.push_back('{i_l2_resp_tag[TW-1:0], i_l2_resp_data});
            else                   exp_q0.push_back('{i_l2_resp_tag[TW-1:0], i_l2_resp_data});
        end
        i_l2_resp_valid  = rsp_act;
        i_ic_resp_ready  = ($urandom_range(0, 99) < 70);
        i_l1d_resp_ready = ($urandom_range(0, 99) < 70);
        #1;
        free = (stage_q.size() == 0) || i_l2_req_ready;
        e0 = i_ic_req_valid && (cnt0 < MO);
        e1 = i_l1d_req_valid && (cnt1 < MO);
        g0 = free && e0 && (!e1 || !pri_m);
        g1 = free && e1 && (!e0 || pri_m);
        chk("ic_req_ready", 64'(o_ic_req_ready), 64'(g0));
        chk("l1d_req_ready", 64'(o_l1d_req_ready), 64'(g1));
        src = i_l2_resp_tag[TW];
        if (rsp_act)
            chk("l2_resp_ready", 64'(o_l2_resp_ready), 64'(src ? i_l1d_resp_ready : i_ic_resp_ready));
        hs0 = rsp_act && !src && i_ic_resp_ready;
        hs1 = rsp_act && src && i_l1d_resp_ready;
        exp_l2_vld = (stage_q.size() != 0);
        exp_rv0 = rsp_act && !src;
        exp_rv1 = rsp_act && src;
        if (g0) stage_q.push_back('{i_ic_req_cmd, i_ic_req_addr, {1'b0, i_ic_req_tag}, i_ic_req_data});
        if (g1) stage_q.push_back('{i_l1d_req_cmd, i_l1d_req_addr, {1'b1, i_l1d_req_tag}, i_l1d_req_data});
        @(posedge clk);
        cnt0 = cnt0 + int'(g0) - int'(hs0);
        cnt1 = cnt1 + int'(g1) - int'(hs1);
        if (g0) pri_m = 1'b1;
        else if (g1) pri_m = 1'b0;
        if (hs0 || hs1) rsp_act = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    initial begin : monitor
        l2req_t e;
        resp_t  r;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                chk("l2_req_valid", 64'(o_l2_req_valid), 64'(exp_l2_vld));
                if (o_l2_req_valid && stage_q.size() != 0) begin
                    e = stage_q[0];
                    chk("l2_req_cmd", 64'(o_l2_req_cmd), 64'(e.cmd));
                    chk("l2_req_addr", 64'(o_l2_req_addr), 64'(e.addr));
                    chk("l2_req_tag", 64'(o_l2_req_tag), 64'(e.tag));
                    chk("l2_req_data", 64'(o_l2_req_data), 64'(e.data));
                    if (i_l2_req_ready) begin
                        void'(stage_q.pop_front());
                        infl_q.push_back(e.tag);
                    end
                end
                chk("ic_resp_valid", 64'(o_ic_resp_valid), 64'(exp_rv0));
                if (o_ic_resp_valid && exp_q0.size() != 0) begin
                    r = exp_q0[0];
                    chk("ic_resp_tag", 64'(o_ic_resp_tag), 64'(r.tag));
                    chk("ic_resp_data", 64'(o_ic_resp_data), 64'(r.data));
                    if (i_ic_resp_ready) void'(exp_q0.pop_front());
                end
                chk("l1d_resp_valid", 64'(o_l1d_resp_valid), 64'(exp_rv1));
                if (o_l1d_resp_valid && exp_q1.size() != 0) begin
                    r = exp_q1[0];
                    chk("l1d_resp_tag", 64'(o_l1d_resp_tag), 64'(r.tag));
                    chk("l1d_resp_data", 64'(o_l1d_resp_data), 64'(r.data));
                    if (i_l1d_resp_ready) void'(exp_q1.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit drained;
        logic [PA-1:0] held_addr;
        idle_inputs();
        i_reset_n = 1'b0;
        cnt0 = 0; cnt1 = 0; pri_m = 1'b0; rsp_act = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_l2_req_valid", 64'(o_l2_req_valid), 64'd0);
        chk("rst_protocol_err", 64'(o_protocol_err), 64'd0);
        chk("rst_ic_req_ready", 64'(o_ic_req_ready), 64'd0);
        chk("rst_l1d_req_ready", 64'(o_l1d_req_ready), 64'd0);
        chk("rst_ic_resp_valid", 64'(o_ic_resp_valid), 64'd0);
        chk("rst_l1d_resp_valid", 64'(o_l1d_resp_valid), 64'd0);
        i_reset_n = 1'b1;

        mon_en = 1'b1;
        for (int i = 0; i < 3000; i++) drive_cycle(1'b1);
        drained = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (stage_q.size() == 0 && infl_q.size() == 0 && !rsp_act) begin
                drained = 1'b1;
                break;
            end
            drive_cycle(1'b0);
        end
        chk("drain_done", 64'(drained), 64'd1);
        mon_en = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("no_err_after_random", 64'(o_protocol_err), 64'd0);

        // Response for ic with nothing outstanding
        @(negedge clk);
        i_l2_resp_valid = 1; i_l2_resp_tag = 5'b0_0011; i_l2_resp_data = 64'hdead_beef_0000_0011;
        i_ic_resp_ready = 1; i_l1d_resp_ready = 0;
        #1;
        chk("err_ic_resp_valid", 64'(o_ic_resp_valid), 64'd1);
        chk("err_ic_resp_tag", 64'(o_ic_resp_tag), 64'h3);
        chk("err_l1d_resp_valid", 64'(o_l1d_resp_valid), 64'd0);
        chk("err_l2_resp_ready", 64'(o_l2_resp_ready), 64'd1);
        chk("err_not_yet", 64'(o_protocol_err), 64'd0);
        @(negedge clk);
        i_l2_resp_tag = 5'b1_0101; i_l2_resp_data = 64'h1234_5678_9abc_def0;
        i_ic_resp_ready = 0; i_l1d_resp_ready = 1;
        #1;
        chk("err_set", 64'(o_protocol_err), 64'd1);
        chk("route_l1d_valid", 64'(o_l1d_resp_valid), 64'd1);
        chk("route_l1d_tag", 64'(o_l1d_resp_tag), 64'h5);
        chk("route_l1d_data", 64'(o_l1d_resp_data), 64'h1234_5678_9abc_def0);
        chk("route_ic_valid", 64'(o_ic_resp_valid), 64'd0);
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        chk("err_sticky", 64'(o_protocol_err), 64'd1);

        // Outstanding limit: counters must have stayed at 0 through the bogus responses
        i_l2_req_ready = 1;
        for (int i = 0; i < MO; i++) begin
            @(negedge clk);
            i_ic_req_valid = 1; i_ic_req_tag = TW'(i); i_ic_req_addr = PA'(i);
            #1;
            chk("limit_ic_grant", 64'(o_ic_req_ready), 64'd1);
        end
        @(negedge clk);
        i_l1d_req_valid = 1;
        #1;
        chk("limit_ic_blocked", 64'(o_ic_req_ready), 64'd0);
        chk("limit_l1d_grant", 64'(o_l1d_req_ready), 64'd1);
        @(negedge clk);
        i_l1d_req_valid = 0;
        i_l2_resp_valid = 1; i_l2_resp_tag = 5'b0_0001; i_ic_resp_ready = 1;
        #1;
        chk("limit_still_blocked", 64'(o_ic_req_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("limit_reenabled", 64'(o_ic_req_ready), 64'd1);
        @(negedge clk);
        i_l2_resp_valid = 0; i_ic_resp_ready = 0;
        #1;
        chk("limit_simul_kept", 64'(o_ic_req_ready), 64'd1);
        @(negedge clk);
        #1;
        chk("limit_full_again", 64'(o_ic_req_ready), 64'd0);

        @(negedge clk);
        idle_inputs();
        i_reset_n = 0;
        @(negedge clk);
        #1;
        chk("rst_clears_err", 64'(o_protocol_err), 64'd0);
        chk("rst_clears_valid", 64'(o_l2_req_valid), 64'd0);
        i_reset_n = 1;

        // Stall with both requesters waiting; pointer starts at ic after reset
        @(negedge clk);
        i_ic_req_valid = 1; i_l1d_req_valid = 1; i_l2_req_ready = 0;
        i_ic_req_addr = PA'(56'h00ab_cdef_0123_45); i_ic_req_tag = 4'h9;
        i_l1d_req_addr = PA'(56'h0011_2233_4455_66); i_l1d_req_tag = 4'h6;
        held_addr = i_ic_req_addr;
        #1;
        chk("stall_first_ic", 64'(o_ic_req_ready), 64'd1);
        chk("stall_first_l1d", 64'(o_l1d_req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_ic_req_addr = PA'({$urandom, $urandom});
            #1;
            chk("stall_valid", 64'(o_l2_req_valid), 64'd1);
            chk("stall_addr", 64'(o_l2_req_addr), 64'(held_addr));
            chk("stall_tag", 64'(o_l2_req_tag), 64'h09);
            chk("stall_ic_ready", 64'(o_ic_req_ready), 64'd0);
            chk("stall_l1d_ready", 64'(o_l1d_req_ready), 64'd0);
        end
        @(negedge clk);
        i_l2_req_ready = 1;
        #1;
        chk("release_addr", 64'(o_l2_req_addr), 64'(held_addr));
        chk("release_l1d_grant", 64'(o_l1d_req_ready), 64'd1);
        chk("release_ic_ready", 64'(o_ic_req_ready), 64'd0);
        @(negedge clk);
        i_ic_req_valid = 0; i_l1d_req_valid = 0; i_l2_req_ready = 0;
        #1;
        chk("l1d_on_l2_valid", 64'(o_l2_req_valid), 64'd1);
        chk("l1d_on_l2_tag", 64'(o_l2_req_tag), 64'h16);
        i_reset_n = 0;
        @(negedge clk);
        #1;
        chk("midreset_drop", 64'(o_l2_req_valid), 64'd0);
        i_reset_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
